// File: rtl/sv_vdma_if.sv
// Register/bus interface of the VRAM block-copy engine.
// slave = engine side, master = system top / CPU side.
interface sv_vdma_if;
   logic        ce;
   logic [5:0]  AB;
   logic        cpu_rwn;
   logic        dma_cs;
   logic        lcd_en;
   logic [7:0]  data_in;
   logic [12:0] vbus_addr;
   logic [15:0] cbus_addr;
   logic        dma_en;
   logic        dma_dir;

   modport slave (
      input  ce, AB, cpu_rwn, dma_cs, lcd_en, data_in,
      output vbus_addr, cbus_addr, dma_en, dma_dir
   );

   modport master (
      output ce, AB, cpu_rwn, dma_cs, lcd_en, data_in,
      input  vbus_addr, cbus_addr, dma_en, dma_dir
   );
endinterface

// File: rtl/sv_vdma.sv
// SuperVision VRAM block-copy engine: owns system registers 0x08-0x0D and
// walks CPU-bus / VRAM addresses one byte per ce period while dma_en is high.
module sv_vdma #(
   parameter int unsigned BLOCK_BYTES = 16
) (
   input logic      clk_sys,
   input logic      reset,
   sv_vdma_if.slave bus
);

   localparam int unsigned CntW = $clog2(256 * BLOCK_BYTES + 1);

   typedef enum logic [0:0] {StIdle, StXfer} state_e;

   state_e          state_q;
   logic [15:0]     cbus_reg_q;
   logic [12:0]     vbus_reg_q;
   logic [7:0]      len_q;
   logic [15:0]     cnt_a_q;
   logic [12:0]     vba_q;
   logic [CntW-1:0] remaining_q;
   logic            dma_en_q;
   logic            dir_q;

   logic            reg_wr;
   logic [CntW-1:0] byte_cnt;

   assign reg_wr = bus.ce & bus.dma_cs & ~bus.cpu_rwn;

   // A length of zero means the full 256 blocks.
   assign byte_cnt = CntW'(((len_q == 8'd0) ? 256 : int'(len_q)) * BLOCK_BYTES);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q     <= StIdle;
         cbus_reg_q  <= '0;
         vbus_reg_q  <= '0;
         len_q       <= '0;
         cnt_a_q     <= '0;
         vba_q       <= '0;
         remaining_q <= '0;
         dma_en_q    <= 1'b0;
         dir_q       <= 1'b0;
      end else if (bus.ce) begin
         unique case (state_q)
            StIdle: begin
               if (reg_wr) begin
                  case (bus.AB)
                     6'h08: cbus_reg_q[7:0]   <= bus.data_in;
                     6'h09: cbus_reg_q[15:8]  <= bus.data_in;
                     6'h0A: vbus_reg_q[7:0]   <= bus.data_in;
                     6'h0B: vbus_reg_q[12:8]  <= bus.data_in[4:0];
                     6'h0C: len_q             <= bus.data_in;
                     6'h0D: begin
                        if (bus.data_in[7] && bus.lcd_en) begin
                           state_q     <= StXfer;
                           dma_en_q    <= 1'b1;
                           cnt_a_q     <= cbus_reg_q;
                           vba_q       <= vbus_reg_q;
                           remaining_q <= byte_cnt;
                           dir_q       <= bus.data_in[6];
                        end
                     end
                     default: ;
                  endcase
               end
            end
            StXfer: begin
               // Programmed registers stay untouched so a restart repeats the copy.
               cnt_a_q     <= cnt_a_q + 16'd1;
               vba_q       <= vba_q + 13'd1;
               remaining_q <= remaining_q - CntW'(1);
               if (remaining_q == CntW'(1)) begin
                  state_q  <= StIdle;
                  dma_en_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= StIdle;
               dma_en_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cbus_addr = cnt_a_q;
   assign bus.vbus_addr = vba_q;
   assign bus.dma_en    = dma_en_q;
   assign bus.dma_dir   = dir_q;

endmodule
